elapsed_time_counter: RTL and testbench
=======================================

// Module: elapsed_time_counter
// PURPOSE
//  Free-running BCD elapsed-time counter (MM:SS, 00:00..99:59) that supplies the
//  Number_Sig time bus to the mode/control logic layer. The logic layer samples it
//  to set sleep/off timers and to raise warnings.
//  clr is driven by the logic layer's zero_signal and holds the count at 00:00.
//  The count runs from TICK_DIV-cycle 1 s ticks generated internally.
// PARAMETERS
//  TICK_DIV  100_000_000  clock cycles per counted second (>=2); sim uses 4
//  WRAP      0            0: saturate at 99:59 with sticky overflow; 1: wrap to 00:00
// PORTS
//  CLK         in   1   system clock, all state on rising edge
//  RST         in   1   asynchronous, active-high reset
//  clr         in   1   level clear (zero_signal); holds count and prescaler at 0
//  run         in   1   count enable; low freezes prescaler and digits
//  Number_Sig  out  24  [23:20]=0, [19:16]=min tens, [15:12]=min units,
//                       [11:8]=sec tens, [7:4]=sec units, [3:0]=0
//  sec_tick    out  1   one-cycle pulse on each counted second
//  overflow    out  1   WRAP=0: sticky at saturation; WRAP=1: 1-cycle pulse on wrap
// BEHAVIOUR
//  - Interface: one clock (CLK). Reset RST is asynchronous and active-high.
//  - Reset (RST=1, async): prescaler=0, all digits=0, Number_Sig=24'h000000,
//    sec_tick=0, overflow=0. Reset released mid-count restarts from 00:00 with a
//    fresh prescaler; no partial second is kept.
//  - Priority per edge: RST > clr > run > hold.
//  - clr=1 (sync): prescaler<=0, digits<=0, sec_tick<=0, overflow<=0, every cycle
//    clr is high. The first tick after clr falls comes exactly TICK_DIV cycles later.
//  - run=0, clr=0: prescaler, digits and overflow hold. sec_tick<=0.
//  - run=1, clr=0: the prescaler counts 0..TICK_DIV-1.
//    - On the edge where prescaler==TICK_DIV-1: prescaler<=0, sec_tick<=1, and the
//      digits advance by one second on the same edge.
//    - The new value is visible in the same cycle sec_tick is high (0-cycle skew).
//    - On all other edges sec_tick<=0.
//  - Digit cascade (all registered, single edge):
//    - sec units 0-9; a carry into sec tens comes from 9.
//    - sec tens 0-5; a carry into min units comes from 5 with sec units at 9.
//    - min units 0-9; a carry into min tens comes from 9.
//    - min tens 0-9.
//    - No digit ever holds a non-BCD value or sec tens > 5.
//  - At 99:59 with a tick:
//    - WRAP=0: digits stay 99:59, overflow<=1 and stays 1 until clr or RST.
//      sec_tick still pulses every second.
//    - WRAP=1: digits<=00:00, overflow=1 for that single cycle only.
//  - Simultaneous terminal count and clr: clr wins. No tick, count=0.
//  - run falling on the terminal-count edge: no tick. The prescaler holds at
//    TICK_DIV-1 and the tick fires on the first edge with run=1 again.
//  - Number_Sig is a direct register output (no combinational path from inputs).
//    [23:20] and [3:0] are constant 0.
// TESTING (TICK_DIV=4 unless noted)
//  1. RST pulse mid-count at 00:07 -> Number_Sig=24'h000000 immediately (async),
//     sec_tick=0, overflow=0.
//  2. run=1 for 40 cycles from 00:00 -> 10 sec_tick pulses, Number_Sig=24'h000100.
//     Continue to 60 ticks total -> 24'h001000.
//  3. Preload via 3599 ticks to 59:59 (24'h059590), one more tick -> 24'h060000.
//  4. Reach 99:59 (24'h099590), WRAP=0, one tick -> value holds, overflow=1 sticky.
//     Then clr for 1 cycle -> 24'h000000, overflow=0.
//     With WRAP=1 -> 24'h000000 and overflow high for exactly 1 cycle.
//  5. clr asserted when prescaler=2 at 00:03 -> next cycle 24'h000000.
//     clr low -> first sec_tick exactly 4 cycles later.
//     clr and terminal count on the same edge -> no tick.
//  6. run=0 for 10 cycles at 00:05, prescaler=1 -> no change, no tick.
//     run=1 -> next tick after 3 more cycles, value 24'h000060.

Source files
------------

// File: rtl/elapsed_time_counter.sv
// BCD MM:SS elapsed-time counter (00:00..99:59) driving the Number_Sig time bus.
// An internal prescaler produces one counted second every TICK_DIV clock cycles.
module elapsed_time_counter #(
   parameter int TICK_DIV = 100_000_000,
   parameter bit WRAP     = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        clr,
   input  logic        run,
   output logic [23:0] Number_Sig,
   output logic        sec_tick,
   output logic        overflow
);

   localparam int             PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [3:0]    r_secU;
   logic [3:0]    r_secT;
   logic [3:0]    r_minU;
   logic [3:0]    r_minT;
   logic          r_tick;
   logic          r_ovf;

   logic          w_terminal;
   logic          w_secUCarry;
   logic          w_secTCarry;
   logic          w_minUCarry;
   logic          w_atMax;
   logic [3:0]    w_secUNext;
   logic [3:0]    w_secTNext;
   logic [3:0]    w_minUNext;
   logic [3:0]    w_minTNext;

   assign w_terminal  = (r_prescEq());
   assign w_secUCarry = (r_secU == 4'd9);
   assign w_secTCarry = w_secUCarry && (r_secT == 4'd5);
   assign w_minUCarry = w_secTCarry && (r_minU == 4'd9);
   assign w_atMax     = w_minUCarry && (r_minT == 4'd9);

   function automatic logic r_prescEq();
      return (r_presc == LAST);
   endfunction

   // One-second increment of the BCD cascade; the 99:59 -> 00:00 rollover falls out
   // naturally and is suppressed in the register block when saturating.
   always_comb begin
      w_secUNext = w_secUCarry ? 4'd0 : r_secU + 4'd1;
      w_secTNext = r_secT;
      w_minUNext = r_minU;
      w_minTNext = r_minT;
      if (w_secUCarry) begin
         w_secTNext = (r_secT == 4'd5) ? 4'd0 : r_secT + 4'd1;
      end
      if (w_secTCarry) begin
         w_minUNext = (r_minU == 4'd9) ? 4'd0 : r_minU + 4'd1;
      end
      if (w_minUCarry) begin
         w_minTNext = (r_minT == 4'd9) ? 4'd0 : r_minT + 4'd1;
      end
   end

   // Priority RST > clr > run > hold; a tick updates the digits on the same edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_presc <= '0;
         r_secU  <= 4'd0;
         r_secT  <= 4'd0;
         r_minU  <= 4'd0;
         r_minT  <= 4'd0;
         r_tick  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (clr) begin
         r_presc <= '0;
         r_secU  <= 4'd0;
         r_secT  <= 4'd0;
         r_minU  <= 4'd0;
         r_minT  <= 4'd0;
         r_tick  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (run && w_terminal) begin
         r_presc <= '0;
         r_tick  <= 1'b1;
         if (w_atMax && !WRAP) begin
            r_ovf <= 1'b1;
         end else begin
            r_secU <= w_secUNext;
            r_secT <= w_secTNext;
            r_minU <= w_minUNext;
            r_minT <= w_minTNext;
            if (WRAP) begin
               r_ovf <= w_atMax;
            end
         end
      end else if (run) begin
         r_presc <= r_presc + 1'b1;
         r_tick  <= 1'b0;
         if (WRAP) begin
            r_ovf <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
         if (WRAP) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign Number_Sig = {4'h0, r_minT, r_minU, r_secT, r_secU, 4'h0};
   assign sec_tick   = r_tick;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_elapsed_time_counter.sv
// Scoreboard bench for elapsed_time_counter: a saturating and a wrapping instance
// share stimulus; every sec_tick is matched against an expected {overflow, Number_Sig}.
module tb_elapsed_time_counter;

   logic        CLK;
   logic        RST;
   logic        clr;
   logic        run;
   logic [23:0] num0;
   logic [23:0] num1;
   logic        tick0;
   logic        tick1;
   logic        ovf0;
   logic        ovf1;

   int nChecks = 0;
   int nPass   = 0;

   logic [24:0] q0[$];
   logic [24:0] q1[$];

   int   mSecs0 = 0;
   logic mOvf0  = 1'b0;
   int   mSecs1 = 0;

   elapsed_time_counter #(.TICK_DIV(4), .WRAP(1'b0)) dutSat (
      .CLK(CLK), .RST(RST), .clr(clr), .run(run),
      .Number_Sig(num0), .sec_tick(tick0), .overflow(ovf0)
   );

   elapsed_time_counter #(.TICK_DIV(4), .WRAP(1'b1)) dutWrap (
      .CLK(CLK), .RST(RST), .clr(clr), .run(run),
      .Number_Sig(num1), .sec_tick(tick1), .overflow(ovf1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [23:0] toBus(input int secs);
      int mm;
      int ss;
      mm = secs / 60;
      ss = secs % 60;
      return {4'h0, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'h0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Inputs change only on the falling edge, then n falling edges pass.
   task automatic applyStimulus(input logic c, input logic r, input int n);
      clr = c;
      run = r;
      repeat (n) @(negedge CLK);
   endtask

   task automatic pushTicks(input int n);
      logic wrapNow;
      for (int i = 0; i < n; i++) begin
         if (mSecs0 == 5999) mOvf0 = 1'b1;
         else mSecs0++;
         wrapNow = (mSecs1 == 5999);
         mSecs1  = wrapNow ? 0 : mSecs1 + 1;
         q0.push_back({mOvf0, toBus(mSecs0)});
         q1.push_back({wrapNow, toBus(mSecs1)});
      end
   endtask

   task automatic modelClear();
      mSecs0 = 0;
      mOvf0  = 1'b0;
      mSecs1 = 0;
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, " sat pending"}, 32'(q0.size()), 32'd0);
      checkOutput({name, " wrap pending"}, 32'(q1.size()), 32'd0);
   endtask

   // Monitor: every presented tick is popped against the scoreboard.
   initial begin
      logic [24:0] e;
      forever begin
         @(negedge CLK);
         if (tick0) begin
            if (q0.size() == 0) begin
               checkOutput("sat unexpected tick", {7'd0, ovf0, num0}, 32'hFFFFFFFF);
            end else begin
               e = q0.pop_front();
               checkOutput("sat tick value", {7'd0, ovf0, num0}, {7'd0, e});
            end
         end
         if (tick1) begin
            if (q1.size() == 0) begin
               checkOutput("wrap unexpected tick", {7'd0, ovf1, num1}, 32'hFFFFFFFF);
            end else begin
               e = q1.pop_front();
               checkOutput("wrap tick value", {7'd0, ovf1, num1}, {7'd0, e});
            end
         end
      end
   end

   initial begin
      RST = 1'b1;
      clr = 1'b0;
      run = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("reset num", {8'd0, num0}, 32'h0);
      checkOutput("reset tick", {31'd0, tick0}, 32'd0);
      checkOutput("reset ovf", {31'd0, ovf0}, 32'd0);
      checkOutput("reset wrap num", {8'd0, num1}, 32'h0);
      RST = 1'b0;

      pushTicks(10);
      applyStimulus(1'b0, 1'b1, 40);
      checkOutput("10 ticks", {8'd0, num0}, 32'h000100);
      checkDrained("10 ticks");
      pushTicks(50);
      applyStimulus(1'b0, 1'b1, 200);
      checkOutput("60 ticks", {8'd0, num0}, 32'h001000);

      pushTicks(3539);
      applyStimulus(1'b0, 1'b1, 3539 * 4);
      checkOutput("59:59", {8'd0, num0}, 32'h059590);
      pushTicks(1);
      applyStimulus(1'b0, 1'b1, 4);
      checkOutput("60:00", {8'd0, num0}, 32'h060000);

      pushTicks(2399);
      applyStimulus(1'b0, 1'b1, 2399 * 4);
      checkOutput("99:59 sat", {8'd0, num0}, 32'h099590);
      checkOutput("99:59 wrap", {8'd0, num1}, 32'h099590);
      checkOutput("99:59 ovf pre", {31'd0, ovf0}, 32'd0);
      pushTicks(1);
      applyStimulus(1'b0, 1'b1, 4);
      checkOutput("sat hold", {8'd0, num0}, 32'h099590);
      checkOutput("wrap zero", {8'd0, num1}, 32'h000000);
      checkOutput("wrap ovf pulse", {31'd0, ovf1}, 32'd1);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("wrap ovf one cycle", {31'd0, ovf1}, 32'd0);
      checkOutput("sat ovf sticky", {31'd0, ovf0}, 32'd1);
      pushTicks(2);
      applyStimulus(1'b0, 1'b1, 7);
      checkOutput("sat ovf still", {31'd0, ovf0}, 32'd1);
      checkOutput("wrap 00:02", {8'd0, num1}, 32'h000020);
      checkDrained("overflow");
      applyStimulus(1'b1, 1'b0, 1);
      modelClear();
      checkOutput("clr num", {8'd0, num0}, 32'h0);
      checkOutput("clr ovf", {31'd0, ovf0}, 32'd0);
      checkOutput("clr wrap num", {8'd0, num1}, 32'h0);

      pushTicks(7);
      applyStimulus(1'b0, 1'b1, 30);
      checkOutput("00:07", {8'd0, num0}, 32'h000070);
      #2 RST = 1'b1;
      #1;
      checkOutput("async rst num", {8'd0, num0}, 32'h0);
      checkOutput("async rst tick", {31'd0, tick0}, 32'd0);
      checkOutput("async rst ovf", {31'd0, ovf0}, 32'd0);
      run = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      modelClear();
      checkDrained("rst");

      pushTicks(3);
      applyStimulus(1'b0, 1'b1, 14);
      checkOutput("00:03", {8'd0, num0}, 32'h000030);
      applyStimulus(1'b1, 1'b1, 1);
      modelClear();
      checkOutput("clr mid-count", {8'd0, num0}, 32'h0);
      pushTicks(1);
      applyStimulus(1'b0, 1'b1, 3);
      checkOutput("no early tick", {31'd0, tick0}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("tick 4 after clr", {31'd0, tick0}, 32'd1);
      checkDrained("clr release");
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 1);
      modelClear();
      checkOutput("clr vs terminal tick", {31'd0, tick0}, 32'd0);
      checkOutput("clr vs terminal num", {8'd0, num0}, 32'h0);

      pushTicks(5);
      applyStimulus(1'b0, 1'b1, 21);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("frozen num", {8'd0, num0}, 32'h000050);
      checkOutput("frozen tick", {31'd0, tick0}, 32'd0);
      pushTicks(1);
      applyStimulus(1'b0, 1'b1, 2);
      checkOutput("resume no tick", {31'd0, tick0}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("resume value", {8'd0, num0}, 32'h000060);
      checkDrained("resume");

      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 3);
      checkOutput("terminal held", {8'd0, num0}, 32'h000060);
      pushTicks(1);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("tick on resume", {8'd0, num0}, 32'h000070);
      checkDrained("terminal resume");
      applyStimulus(1'b0, 1'b0, 2);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
